// File: rtl/seven_seg_display_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_display_if : nibble inputs and segment outputs of one digit
// Revision: 1.0
// ---------------------------------------------------------------------------
interface seven_seg_display_if;
   logic i1;
   logic i2;
   logic i3;
   logic i4;
   logic a;
   logic b;
   logic c;
   logic d;
   logic e;
   logic f;
   logic g;

   modport master (
      output i1, i2, i3, i4,
      input  a, b, c, d, e, f, g
   );

   modport slave (
      input  i1, i2, i3, i4,
      output a, b, c, d, e, f, g
   );
endinterface
`default_nettype wire

// File: rtl/seven_seg_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_display : registered hex-to-seven-segment decoder, one digit
// Revision: 1.0
// ---------------------------------------------------------------------------
module seven_seg_display #(
   parameter bit ACTIVE_LOW = 1'b0,
   parameter bit HEX_MODE   = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   seven_seg_display_if.slave bus
);

   localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};

   logic [3:0] nibble;
   logic [6:0] lit;
   logic [6:0] drive;
   logic [6:0] seg_q;

   assign nibble = {bus.i1, bus.i2, bus.i3, bus.i4};

   // Bit order is {a,b,c,d,e,f,g}; 1 means the segment is lit.
   always_comb begin
      lit = 7'b0000000;
      case (nibble)
         4'd0:    lit = 7'b1111110;
         4'd1:    lit = 7'b0110000;
         4'd2:    lit = 7'b1101101;
         4'd3:    lit = 7'b1111001;
         4'd4:    lit = 7'b0110011;
         4'd5:    lit = 7'b1011011;
         4'd6:    lit = 7'b1011111;
         4'd7:    lit = 7'b1110000;
         4'd8:    lit = 7'b1111111;
         4'd9:    lit = 7'b1111011;
         4'd10:   lit = HEX_MODE ? 7'b1110111 : 7'b0000000;
         4'd11:   lit = HEX_MODE ? 7'b0011111 : 7'b0000000;
         4'd12:   lit = HEX_MODE ? 7'b1001110 : 7'b0000000;
         4'd13:   lit = HEX_MODE ? 7'b0111101 : 7'b0000000;
         4'd14:   lit = HEX_MODE ? 7'b1001111 : 7'b0000000;
         4'd15:   lit = HEX_MODE ? 7'b1000111 : 7'b0000000;
         default: lit = 7'b0000000;
      endcase
   end

   assign drive = ACTIVE_LOW ? ~lit : lit;

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= SEG_OFF;
      end else begin
         seg_q <= drive;
      end
   end

   assign bus.a = seg_q[6];
   assign bus.b = seg_q[5];
   assign bus.c = seg_q[4];
   assign bus.d = seg_q[3];
   assign bus.e = seg_q[2];
   assign bus.f = seg_q[1];
   assign bus.g = seg_q[0];

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seven_seg_display : three parameter variants driven in parallel
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_seven_seg_display;

   // Variant k: 0 = (AL0,HEX1), 1 = (AL0,HEX0), 2 = (AL1,HEX1)
   localparam bit [2:0] HEX_CFG = 3'b101;
   localparam bit [2:0] AL_CFG  = 3'b100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] n   = 4'd0;
   int         checks = 0;
   int         passes = 0;
   string      glyph [16];
   logic [6:0] seg [3];

   seven_seg_display_if bus0 ();
   seven_seg_display_if bus1 ();
   seven_seg_display_if bus2 ();

   seven_seg_display #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   seven_seg_display #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   seven_seg_display #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   assign {bus0.i1, bus0.i2, bus0.i3, bus0.i4} = n;
   assign {bus1.i1, bus1.i2, bus1.i3, bus1.i4} = n;
   assign {bus2.i1, bus2.i2, bus2.i3, bus2.i4} = n;
   assign seg[0] = {bus0.a, bus0.b, bus0.c, bus0.d, bus0.e, bus0.f, bus0.g};
   assign seg[1] = {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.f, bus1.g};
   assign seg[2] = {bus2.a, bus2.b, bus2.c, bus2.d, bus2.e, bus2.f, bus2.g};

   always #5 clk = ~clk;

   // Glyphs are described by the letters of their lit segments.
   function automatic logic [6:0] glyph_bits(input string s);
      logic [6:0] bits = 7'b0000000;
      for (int i = 0; i < s.len(); i++) begin
         bits[6 - (int'(s[i]) - 97)] = 1'b1;
      end
      return bits;
   endfunction

   function automatic logic [6:0] model(input int k, input logic [3:0] nib, input logic r);
      logic [6:0] lit;
      if (r)                             lit = 7'b0000000;
      else if (nib < 4'd10 || HEX_CFG[k]) lit = glyph_bits(glyph[nib]);
      else                               lit = 7'b0000000;
      return AL_CFG[k] ? ~lit : lit;
   endfunction

   task automatic apply(input logic [3:0] nib, input logic r);
      n   = nib;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int cyc = 0; cyc < 2; cyc++) begin
         apply(4'd8, 1'b1);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (seg[k] !== model(k, 4'd8, 1'b1))
               $display("FAIL reset dut%0d got=%b want=%b", k, seg[k], model(k, 4'd8, 1'b1));
            else passes++;
         end
      end
      apply(4'd8, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (seg[k] !== model(k, 4'd8, 1'b0))
            $display("FAIL reset_release dut%0d got=%b want=%b", k, seg[k], model(k, 4'd8, 1'b0));
         else passes++;
      end
   endtask

   task automatic test_sweep();
      for (int v = 0; v < 16; v++) begin
         apply(4'(v), 1'b0);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (seg[k] !== model(k, 4'(v), 1'b0))
               $display("FAIL sweep dut%0d n=%0d got=%b want=%b", k, v, seg[k], model(k, 4'(v), 1'b0));
            else passes++;
         end
      end
   endtask

   task automatic test_active_low();
      apply(4'd1, 1'b0);
      checks++;
      if (seg[2] !== 7'b1001111) $display("FAIL active_low_one got=%b want=1001111", seg[2]);
      else passes++;
      apply(4'd1, 1'b1);
      checks++;
      if (seg[2] !== 7'b1111111) $display("FAIL active_low_reset got=%b want=1111111", seg[2]);
      else passes++;
   endtask

   task automatic test_latency_mid_reset();
      apply(4'd0, 1'b0);
      #2 n = 4'd1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (seg[k] !== model(k, 4'd0, 1'b0))
            $display("FAIL hold_between_edges dut%0d got=%b want=%b", k, seg[k], model(k, 4'd0, 1'b0));
         else passes++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (seg[k] !== model(k, 4'd1, 1'b0))
            $display("FAIL next_edge dut%0d got=%b want=%b", k, seg[k], model(k, 4'd1, 1'b0));
         else passes++;
      end
      apply(4'd6, 1'b0);
      apply(4'd6, 1'b1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (seg[k] !== model(k, 4'd6, 1'b1))
            $display("FAIL mid_reset dut%0d got=%b want=%b", k, seg[k], model(k, 4'd6, 1'b1));
         else passes++;
      end
      apply(4'd3, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (seg[k] !== model(k, 4'd3, 1'b0))
            $display("FAIL after_release dut%0d got=%b want=%b", k, seg[k], model(k, 4'd3, 1'b0));
         else passes++;
      end
   endtask

   task automatic test_random();
      logic [3:0] nib;
      logic       r;
      for (int t = 0; t < 60; t++) begin
         nib = 4'($urandom_range(15, 0));
         r   = ($urandom_range(7, 0) == 0);
         apply(nib, r);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (seg[k] !== model(k, nib, r))
               $display("FAIL random dut%0d n=%0d rst=%0b got=%b want=%b", k, nib, r, seg[k], model(k, nib, r));
            else passes++;
         end
      end
   endtask

   initial begin
      glyph[0]  = "abcdef";  glyph[1]  = "bc";      glyph[2]  = "abdeg";   glyph[3]  = "abcdg";
      glyph[4]  = "bcfg";    glyph[5]  = "acdfg";   glyph[6]  = "acdefg";  glyph[7]  = "abc";
      glyph[8]  = "abcdefg"; glyph[9]  = "abcdfg";  glyph[10] = "abcefg";  glyph[11] = "cdefg";
      glyph[12] = "adef";    glyph[13] = "bcdeg";   glyph[14] = "adefg";   glyph[15] = "aefg";
      test_reset();
      test_sweep();
      test_active_low();
      test_latency_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
